// File: rtl/arm_multicycle_control_if.sv
// Control bus between the multicycle ARM sequencer and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface arm_multicycle_control_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_control;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [3:0] flags;
  logic       instr_done;
  logic       fault;

  modport master (
    input  cond, op, funct, rd, alu_flags, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a,
           alu_src_b, alu_control, result_src, imm_src, reg_src, flags,
           instr_done, fault
  );

  modport slave (
    output cond, op, funct, rd, alu_flags, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a,
           alu_src_b, alu_control, result_src, imm_src, reg_src, flags,
           instr_done, fault
  );
endinterface

// File: rtl/arm_multicycle_control.sv
// Multicycle ARM sequencer: one shared ALU, one unified memory, NZCV flags and
// a per-access memory wait timeout that parks the machine in FAULT.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE | evaluate condition, ALU forms PC+8
// MEMADR | ALU forms base + offset
// MEMRD  | load access, wait for memory
// MEMWB  | write loaded data to Rd
// MEMWR  | store access, wait for memory
// EXECR  | ALU op with register operand B
// EXECI  | ALU op with immediate operand
// ALUWB  | write ALU result to Rd
// BRANCH | PC <= PC+8 + offset
// FAULT  | memory timeout, held until reset
module arm_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  arm_multicycle_control_if.master        ctl_bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_flags;
  logic       r_fault;
  logic       r_cond_ex;
  logic [7:0] r_wait_cnt;

  logic [3:0] w_cmd;
  logic       w_s_or_l;
  logic       w_imm;
  logic       w_is_cmp;
  logic       w_cv_update;
  logic       w_cond_ex;
  logic [1:0] w_alu_dec;
  logic       w_wait_state;
  logic       w_timeout;
  logic       w_n, w_z, w_c, w_v;

  logic       w_pc_write, w_ir_write, w_adr_src, w_mem_write, w_reg_write;
  logic       w_alu_src_a, w_instr_done;
  logic [1:0] w_alu_src_b, w_alu_control, w_result_src;

  assign w_cmd       = ctl_bus.funct[4:1];
  assign w_s_or_l    = ctl_bus.funct[0];
  assign w_imm       = ctl_bus.funct[5];
  assign w_is_cmp    = (w_cmd == 4'b1010);
  assign w_cv_update = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) || (w_cmd == 4'b1010);
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ex = 1'b1;
    case (ctl_bus.cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = !w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = !w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = !w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = !w_v;
      4'b1000: w_cond_ex = w_c && !w_z;
      4'b1001: w_cond_ex = !w_c || w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = !w_z && (w_n == w_v);
      4'b1101: w_cond_ex = w_z || (w_n != w_v);
      default: w_cond_ex = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_dec = ALU_ADD;
    case (w_cmd)
      4'b0010, 4'b1010: w_alu_dec = ALU_SUB;
      4'b0000:          w_alu_dec = ALU_AND;
      4'b1100:          w_alu_dec = ALU_ORR;
      default:          w_alu_dec = ALU_ADD;
    endcase
  end

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // A ready arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout    = w_wait_state && !ctl_bus.mem_ready && (r_wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (ctl_bus.mem_ready) w_next_state = S_DECODE;
        else if (w_timeout)    w_next_state = S_FAULT;
      end
      S_DECODE: begin
        unique case (ctl_bus.op)
          2'b01:   w_next_state = S_MEMADR;
          2'b00:   w_next_state = w_imm ? S_EXECI : S_EXECR;
          2'b10:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: w_next_state = w_s_or_l ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (ctl_bus.mem_ready) w_next_state = S_MEMWB;
        else if (w_timeout)    w_next_state = S_FAULT;
      end
      S_MEMWB: w_next_state = S_FETCH;
      S_MEMWR: begin
        if (ctl_bus.mem_ready) w_next_state = S_FETCH;
        else if (w_timeout)    w_next_state = S_FAULT;
      end
      S_EXECR, S_EXECI: w_next_state = S_ALUWB;
      S_ALUWB:          w_next_state = S_FETCH;
      S_BRANCH:         w_next_state = S_FETCH;
      default:          w_next_state = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags    <= 4'b0000;
      r_fault    <= 1'b0;
      r_cond_ex  <= 1'b0;
      r_wait_cnt <= 8'd0;
    end else begin
      if (w_next_state != r_state)
        r_wait_cnt <= 8'd0;
      else if (w_wait_state && !ctl_bus.mem_ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;

      if (w_next_state == S_FAULT)
        r_fault <= 1'b1;

      if (r_state == S_DECODE)
        r_cond_ex <= w_cond_ex;

      // Logical ops leave C and V untouched.
      if ((r_state == S_EXECR || r_state == S_EXECI) && w_s_or_l && r_cond_ex) begin
        r_flags[3:2] <= ctl_bus.alu_flags[3:2];
        if (w_cv_update)
          r_flags[1:0] <= ctl_bus.alu_flags[1:0];
      end
    end
  end

  always_comb begin
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_control = ALU_ADD;
    w_result_src  = 2'b00;
    w_instr_done  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = ctl_bus.mem_ready;
        w_pc_write   = ctl_bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_instr_done = (ctl_bus.op == 2'b11);
      end
      S_MEMADR: w_alu_src_b = 2'b01;
      S_MEMRD:  w_adr_src   = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = r_cond_ex;
        w_pc_write   = r_cond_ex && (ctl_bus.rd == 4'd15);
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_adr_src    = 1'b1;
        w_mem_write  = r_cond_ex && ctl_bus.mem_ready;
        w_instr_done = ctl_bus.mem_ready;
      end
      S_EXECR: w_alu_control = w_alu_dec;
      S_EXECI: begin
        w_alu_src_b   = 2'b01;
        w_alu_control = w_alu_dec;
      end
      S_ALUWB: begin
        w_reg_write  = r_cond_ex && !w_is_cmp;
        w_pc_write   = r_cond_ex && !w_is_cmp && (ctl_bus.rd == 4'd15);
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = r_cond_ex;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low while reset is held so nothing writes mid-reset.
  assign ctl_bus.pc_write    = w_pc_write   && rst_n;
  assign ctl_bus.ir_write    = w_ir_write   && rst_n;
  assign ctl_bus.mem_write   = w_mem_write  && rst_n;
  assign ctl_bus.reg_write   = w_reg_write  && rst_n;
  assign ctl_bus.instr_done  = w_instr_done && rst_n;
  assign ctl_bus.adr_src     = w_adr_src;
  assign ctl_bus.alu_src_a   = w_alu_src_a;
  assign ctl_bus.alu_src_b   = w_alu_src_b;
  assign ctl_bus.alu_control = w_alu_control;
  assign ctl_bus.result_src  = w_result_src;
  assign ctl_bus.imm_src     = ctl_bus.op;
  assign ctl_bus.reg_src     = {ctl_bus.op == 2'b01, ctl_bus.op == 2'b10};
  assign ctl_bus.flags       = r_flags;
  assign ctl_bus.fault       = r_fault;

endmodule

// File: tb/tb_arm_multicycle_control.sv
// Directed vector bench for the multicycle ARM controller: one vector per clock,
// plus hand-built sequences for mid-instruction reset, timeout boundary and fault.
module tb_arm_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arm_multicycle_control_if bus_if ();

  arm_multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctl_bus (bus_if)
  );

  typedef struct {
    string      name;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       ready;
    logic [7:0] sel;    // {adr_src, alu_src_a, alu_src_b, alu_control, result_src}
    logic [4:0] en;     // {pc_write, ir_write, mem_write, reg_write, instr_done}
    logic [3:0] flags;
    logic       fault;
  } vec_t;

  localparam logic [7:0] SL_FETCH   = 8'b0_1_10_00_10;
  localparam logic [7:0] SL_MEMADR  = 8'b0_0_01_00_00;
  localparam logic [7:0] SL_MEM     = 8'b1_0_00_00_00;
  localparam logic [7:0] SL_MEMWB   = 8'b0_0_00_00_01;
  localparam logic [7:0] SL_EXR_ADD = 8'b0_0_00_00_00;
  localparam logic [7:0] SL_EXR_SUB = 8'b0_0_00_01_00;
  localparam logic [7:0] SL_EXI_ADD = 8'b0_0_01_00_00;
  localparam logic [7:0] SL_EXI_ORR = 8'b0_0_01_11_00;
  localparam logic [7:0] SL_ALUWB   = 8'b0_0_00_00_00;
  localparam logic [7:0] SL_BR      = 8'b0_0_01_00_10;
  localparam logic [7:0] SL_FAULT   = 8'b0_0_00_00_00;

  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_FETCH = 5'b11000;
  localparam logic [4:0] EN_DONE  = 5'b00001;
  localparam logic [4:0] EN_RWD   = 5'b00011;
  localparam logic [4:0] EN_PCD   = 5'b10001;
  localparam logic [4:0] EN_PCRWD = 5'b10011;
  localparam logic [4:0] EN_MWD   = 5'b00101;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  logic [3:0] cur_c;
  logic [1:0] cur_o;
  logic [5:0] cur_f;
  logic [3:0] cur_r;

  task automatic ins(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    cur_c = c; cur_o = o; cur_f = f; cur_r = r;
  endtask

  function automatic vec_t cv(string nm, logic [3:0] af, logic rdy, logic [7:0] sel,
                              logic [4:0] en, logic [3:0] fl, logic flt);
    vec_t v;
    v.name = nm; v.cond = cur_c; v.op = cur_o; v.funct = cur_f; v.rd = cur_r;
    v.alu_flags = af; v.ready = rdy; v.sel = sel; v.en = en; v.flags = fl; v.fault = flt;
    return v;
  endfunction

  task automatic row(string nm, logic [3:0] af, logic rdy, logic [7:0] sel, logic [4:0] en, logic [3:0] fl);
    tbl.push_back(cv(nm, af, rdy, sel, en, fl, 1'b0));
  endtask

  task automatic drive_check(input vec_t v);
    logic [21:0] got, exp;
    bus_if.cond      = v.cond;
    bus_if.op        = v.op;
    bus_if.funct     = v.funct;
    bus_if.rd        = v.rd;
    bus_if.alu_flags = v.alu_flags;
    bus_if.mem_ready = v.ready;
    #1;
    got = {bus_if.adr_src, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_control, bus_if.result_src,
           bus_if.pc_write, bus_if.ir_write, bus_if.mem_write, bus_if.reg_write, bus_if.instr_done,
           bus_if.imm_src, bus_if.reg_src, bus_if.flags, bus_if.fault};
    exp = {v.sel, v.en, v.op, (v.op == 2'b01), (v.op == 2'b10), v.flags, v.fault};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got sel=%b en=%b imm=%b rsrc=%b flags=%b fault=%b, want sel=%b en=%b imm=%b rsrc=%b flags=%b fault=%b",
               v.name, got[21:14], got[13:9], got[8:7], got[6:5], got[4:1], got[0],
               exp[21:14], exp[13:9], exp[8:7], exp[6:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t v);
    drive_check(v);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // ADD R1,R2,#5
    ins(4'b1110, 2'b00, 6'b101000, 4'd1);
    row("add_fetch",  4'b0000, 1, SL_FETCH,   EN_FETCH, 4'b0000);
    row("add_decode", 4'b0000, 1, SL_FETCH,   EN_NONE,  4'b0000);
    row("add_execi",  4'b1111, 1, SL_EXI_ADD, EN_NONE,  4'b0000);
    row("add_aluwb",  4'b0000, 1, SL_ALUWB,   EN_RWD,   4'b0000);
    // SUBS R3,A,B
    ins(4'b1110, 2'b00, 6'b000101, 4'd3);
    row("subs_fetch",  4'b0000, 1, SL_FETCH,   EN_FETCH, 4'b0000);
    row("subs_decode", 4'b0000, 1, SL_FETCH,   EN_NONE,  4'b0000);
    row("subs_execr",  4'b0110, 1, SL_EXR_SUB, EN_NONE,  4'b0000);
    row("subs_aluwb",  4'b0000, 1, SL_ALUWB,   EN_RWD,   4'b0110);
    // BEQ taken (Z=1)
    ins(4'b0000, 2'b10, 6'b100000, 4'd0);
    row("beq_fetch",  4'b0000, 1, SL_FETCH, EN_FETCH, 4'b0110);
    row("beq_decode", 4'b0000, 1, SL_FETCH, EN_NONE,  4'b0110);
    row("beq_branch", 4'b0000, 1, SL_BR,    EN_PCD,   4'b0110);
    // BNE not taken
    ins(4'b0001, 2'b10, 6'b100000, 4'd0);
    row("bne_fetch",  4'b0000, 1, SL_FETCH, EN_FETCH, 4'b0110);
    row("bne_decode", 4'b0000, 1, SL_FETCH, EN_NONE,  4'b0110);
    row("bne_branch", 4'b0000, 1, SL_BR,    EN_DONE,  4'b0110);
    // LDR R4 with three wait cycles
    ins(4'b1110, 2'b01, 6'b011001, 4'd4);
    row("ldr_fetch",  4'b0000, 1, SL_FETCH,  EN_FETCH, 4'b0110);
    row("ldr_decode", 4'b0000, 1, SL_FETCH,  EN_NONE,  4'b0110);
    row("ldr_memadr", 4'b0000, 1, SL_MEMADR, EN_NONE,  4'b0110);
    row("ldr_memrd1", 4'b0000, 0, SL_MEM,    EN_NONE,  4'b0110);
    row("ldr_memrd2", 4'b0000, 0, SL_MEM,    EN_NONE,  4'b0110);
    row("ldr_memrd3", 4'b0000, 0, SL_MEM,    EN_NONE,  4'b0110);
    row("ldr_memrd4", 4'b0000, 1, SL_MEM,    EN_NONE,  4'b0110);
    row("ldr_memwb",  4'b0000, 1, SL_MEMWB,  EN_RWD,   4'b0110);
    // ORRS: N,Z captured, C,V kept
    ins(4'b1110, 2'b00, 6'b111001, 4'd5);
    row("orrs_fetch",  4'b0000, 1, SL_FETCH,   EN_FETCH, 4'b0110);
    row("orrs_decode", 4'b0000, 1, SL_FETCH,   EN_NONE,  4'b0110);
    row("orrs_execi",  4'b1011, 1, SL_EXI_ORR, EN_NONE,  4'b0110);
    row("orrs_aluwb",  4'b0000, 1, SL_ALUWB,   EN_RWD,   4'b1010);
    // STREQ with Z=0: condition fails
    ins(4'b0000, 2'b01, 6'b011000, 4'd6);
    row("strf_fetch",  4'b0000, 1, SL_FETCH,  EN_FETCH, 4'b1010);
    row("strf_decode", 4'b0000, 1, SL_FETCH,  EN_NONE,  4'b1010);
    row("strf_memadr", 4'b0000, 1, SL_MEMADR, EN_NONE,  4'b1010);
    row("strf_memwr0", 4'b0000, 0, SL_MEM,    EN_NONE,  4'b1010);
    row("strf_memwr1", 4'b0000, 1, SL_MEM,    EN_DONE,  4'b1010);
    // CMP: flags update, no register write
    ins(4'b1110, 2'b00, 6'b010101, 4'd0);
    row("cmp_fetch",  4'b0000, 1, SL_FETCH,   EN_FETCH, 4'b1010);
    row("cmp_decode", 4'b0000, 1, SL_FETCH,   EN_NONE,  4'b1010);
    row("cmp_execr",  4'b0011, 1, SL_EXR_SUB, EN_NONE,  4'b1010);
    row("cmp_aluwb",  4'b0000, 1, SL_ALUWB,   EN_DONE,  4'b0011);
    // STR always
    ins(4'b1110, 2'b01, 6'b011000, 4'd6);
    row("str_fetch",  4'b0000, 1, SL_FETCH,  EN_FETCH, 4'b0011);
    row("str_decode", 4'b0000, 1, SL_FETCH,  EN_NONE,  4'b0011);
    row("str_memadr", 4'b0000, 1, SL_MEMADR, EN_NONE,  4'b0011);
    row("str_memwr",  4'b0000, 1, SL_MEM,    EN_MWD,   4'b0011);
    // NOP (op=11) retires in DECODE
    ins(4'b1110, 2'b11, 6'b000000, 4'd0);
    row("nop_fetch",  4'b0000, 1, SL_FETCH, EN_FETCH, 4'b0011);
    row("nop_decode", 4'b0000, 1, SL_FETCH, EN_DONE,  4'b0011);
    // ADD PC,R2,#5 writes PC as well
    ins(4'b1110, 2'b00, 6'b101000, 4'd15);
    row("addpc_fetch",  4'b0000, 1, SL_FETCH,   EN_FETCH, 4'b0011);
    row("addpc_decode", 4'b0000, 1, SL_FETCH,   EN_NONE,  4'b0011);
    row("addpc_execi",  4'b0000, 1, SL_EXI_ADD, EN_NONE,  4'b0011);
    row("addpc_aluwb",  4'b0000, 1, SL_ALUWB,   EN_PCRWD, 4'b0011);

    // Reset state, enables held low while in reset even with mem_ready=1
    ins(4'b1110, 2'b00, 6'b101000, 4'd1);
    @(negedge clk);
    drive_check(cv("reset_state", 4'b0000, 1, SL_FETCH, EN_NONE, 4'b0000, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted during EXECR of ADDS: no flag or register write
    ins(4'b1110, 2'b00, 6'b001001, 4'd7);
    apply(cv("adds_fetch",  4'b0000, 1, SL_FETCH, EN_FETCH, 4'b0011, 1'b0));
    apply(cv("adds_decode", 4'b0000, 1, SL_FETCH, EN_NONE,  4'b0011, 1'b0));
    drive_check(cv("adds_execr", 4'b1111, 1, SL_EXR_ADD, EN_NONE, 4'b0011, 1'b0));
    rst_n = 1'b0;
    drive_check(cv("adds_abort", 4'b1111, 1, SL_FETCH, EN_NONE, 4'b0000, 1'b0));
    @(negedge clk);
    drive_check(cv("adds_in_rst", 4'b1111, 1, SL_FETCH, EN_NONE, 4'b0000, 1'b0));
    rst_n = 1'b1;
    apply(cv("adds2_fetch",  4'b0000, 1, SL_FETCH,   EN_FETCH, 4'b0000, 1'b0));
    apply(cv("adds2_decode", 4'b0000, 1, SL_FETCH,   EN_NONE,  4'b0000, 1'b0));
    apply(cv("adds2_execr",  4'b1100, 1, SL_EXR_ADD, EN_NONE,  4'b0000, 1'b0));
    apply(cv("adds2_aluwb",  4'b0000, 1, SL_ALUWB,   EN_RWD,   4'b1100, 1'b0));

    // Ready arrives on the last allowed wait cycle: no fault
    ins(4'b1110, 2'b00, 6'b101000, 4'd1);
    for (int k = 0; k < 3; k++)
      apply(cv("edge_wait", 4'b0000, 0, SL_FETCH, EN_NONE, 4'b1100, 1'b0));
    apply(cv("edge_fetch",  4'b0000, 1, SL_FETCH,   EN_FETCH, 4'b1100, 1'b0));
    apply(cv("edge_decode", 4'b0000, 1, SL_FETCH,   EN_NONE,  4'b1100, 1'b0));
    apply(cv("edge_execi",  4'b0000, 1, SL_EXI_ADD, EN_NONE,  4'b1100, 1'b0));
    apply(cv("edge_aluwb",  4'b0000, 1, SL_ALUWB,   EN_RWD,   4'b1100, 1'b0));

    // Four waiting cycles in FETCH: timeout to sticky FAULT
    for (int k = 0; k < 4; k++)
      apply(cv("to_wait", 4'b0000, 0, SL_FETCH, EN_NONE, 4'b1100, 1'b0));
    for (int k = 0; k < 3; k++)
      apply(cv("to_fault", 4'b0000, 1, SL_FAULT, EN_NONE, 4'b1100, 1'b1));
    rst_n = 1'b0;
    drive_check(cv("fault_rst", 4'b0000, 1, SL_FETCH, EN_NONE, 4'b0000, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(cv("post_fault_fetch", 4'b0000, 1, SL_FETCH, EN_FETCH, 4'b0000, 1'b0));
    apply(cv("post_fault_decode", 4'b0000, 1, SL_FETCH, EN_NONE, 4'b0000, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
